// File: rtl/dm_tap_pkg.sv
// Shared TAP types: the 16-state FSM encoding, IR codes and the next-state helper.
package dm_tap_pkg;

  typedef enum logic [3:0] {
    TestLogicReset, RunTestIdle,
    SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr, UpdateDr,
    SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
  } tap_state_e;

  localparam int          IdcodeWidth = 32;
  localparam logic [31:0] IR_BYPASS0  = 32'h0;
  localparam logic [31:0] IR_IDCODE   = 32'h1;
  // BYPASS1 is the all-ones code of whatever IR width is configured.

  // Pad bit positions inside the synchroniser word
  localparam int PadTck  = 0;
  localparam int PadTms  = 1;
  localparam int PadTdi  = 2;
  localparam int PadTrst = 3;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TestLogicReset: return tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    return tms ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   return tms ? SelectIrScan   : CaptureDr;
      CaptureDr:      return tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        return tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        return tms ? UpdateDr       : PauseDr;
      PauseDr:        return tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        return tms ? UpdateDr       : ShiftDr;
      UpdateDr:       return tms ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   return tms ? TestLogicReset : CaptureIr;
      CaptureIr:      return tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        return tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        return tms ? UpdateIr       : PauseIr;
      PauseIr:        return tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        return tms ? UpdateIr       : ShiftIr;
      UpdateIr:       return tms ? SelectDrScan   : RunTestIdle;
      default:        return TestLogicReset;
    endcase
  endfunction

endpackage

// File: rtl/dmi_jtag_tap_os_if.sv
// User-DR side of the oversampled TAP: strobes, state levels, selects and serial returns.
interface dmi_jtag_tap_os_if #(
  parameter int NumUserDr = 2
) ();
  logic                 tck_rise_o;
  logic                 capture_o;
  logic                 shift_o;
  logic                 update_o;
  logic                 tdi_o;
  logic [NumUserDr-1:0] dr_select_o;
  logic [NumUserDr-1:0] user_tdo_i;
  logic                 dmi_clear_o;

  modport master (
    output tck_rise_o, capture_o, shift_o, update_o, tdi_o, dr_select_o, dmi_clear_o,
    input  user_tdo_i
  );
  modport slave (
    input  tck_rise_o, capture_o, shift_o, update_o, tdi_o, dr_select_o, dmi_clear_o,
    output user_tdo_i
  );
endinterface

// File: rtl/dmi_jtag_tap_os_edge_sync.sv
// Pad synchronisers and TCK edge strobes for the system-clocked TAP.
// TAP_TCK_GLITCH_FILTER_EN: require the synced TCK to hold for 2 clk before an edge counts.
module tap_edge_sync
  import dm_tap_pkg::*;
#(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tck_i,
  input  logic tms_i,
  input  logic td_i,
  input  logic trst_ni,
  output logic tck_rise_o,
  output logic tck_fall_o,
  output logic tms_o,
  output logic tdi_o,
  output logic trst_no
);

  logic [SyncStages-1:0][3:0] sync_q;
  logic [3:0]                 pad_d;
  logic                       tck_s, tck_prev_q, rise_d, fall_d;

  always_comb begin
    pad_d          = '0;
    pad_d[PadTck]  = tck_i;
    pad_d[PadTms]  = tms_i;
    pad_d[PadTdi]  = td_i;
    pad_d[PadTrst] = trst_ni;
  end

  assign tck_s   = sync_q[SyncStages-1][PadTck];
  assign trst_no = sync_q[SyncStages-1][PadTrst];

`ifdef TAP_TCK_GLITCH_FILTER_EN
  logic tck_filt_q, stable;
  assign stable = (tck_s == tck_prev_q);
  assign rise_d = stable &  tck_s & ~tck_filt_q;
  assign fall_d = stable & ~tck_s &  tck_filt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)       tck_filt_q <= 1'b0;
    else if (stable) tck_filt_q <= tck_s;
  end
`else
  assign rise_d =  tck_s & ~tck_prev_q;
  assign fall_d = ~tck_s &  tck_prev_q;
`endif

  // TMS/TDI are registered alongside the strobe so they line up with the edge they belong to
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      tck_prev_q <= 1'b0;
      tck_rise_o <= 1'b0;
      tck_fall_o <= 1'b0;
      tms_o      <= 1'b0;
      tdi_o      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SyncStages-2:0], pad_d};
      tck_prev_q <= tck_s;
      tck_rise_o <= rise_d;
      tck_fall_o <= fall_d;
      tms_o      <= sync_q[SyncStages-1][PadTms];
      tdi_o      <= sync_q[SyncStages-1][PadTdi];
    end
  end

endmodule

// File: rtl/dmi_jtag_tap_os.sv
// Oversampled JTAG TAP: FSM, IR, IDCODE/BYPASS and TDO, all clocked by clk_i.
// TCK edges come from tap_edge_sync (see TAP_TCK_GLITCH_FILTER_EN there).
module dmi_jtag_tap_os
  import dm_tap_pkg::*;
#(
  parameter int          IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h00000001,
  parameter int          NumUserDr   = 2,
  parameter int          UserIrBase  = 'h10,
  parameter int          SyncStages  = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tck_i,
  input  logic tms_i,
  input  logic td_i,
  input  logic trst_ni,
  output logic td_o,
  output logic tdo_oe_o,
  dmi_jtag_tap_os_if.master dmi
);

  logic tck_rise, tck_fall, tms_s, tdi_s, trst_s, tap_rst;

  tap_edge_sync #(.SyncStages(SyncStages)) u_edge (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tck_i      (tck_i),
    .tms_i      (tms_i),
    .td_i       (td_i),
    .trst_ni    (trst_ni),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall),
    .tms_o      (tms_s),
    .tdi_o      (tdi_s),
    .trst_no    (trst_s)
  );

  assign tap_rst = rst_i | ~trst_s;

  tap_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (tap_rst) state_q <= TestLogicReset;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) state_d = tap_next(state_q, tms_s);
  end

  logic [IrLength-1:0]    ir_q, ir_shift_q;
  logic [IdcodeWidth-1:0] idcode_q;
  logic                   bypass_q;
  logic [NumUserDr-1:0]   dr_sel;
  logic                   ir_bypass_code, idcode_sel, bypass_sel, tdo_d;

  assign ir_bypass_code = (ir_q == IrLength'(IR_BYPASS0)) || (ir_q == '1);
  assign idcode_sel     = (ir_q == IrLength'(IR_IDCODE));

  for (genvar k = 0; k < NumUserDr; k++) begin : g_sel
    assign dr_sel[k] = ~ir_bypass_code && (ir_q == IrLength'(UserIrBase + k));
  end

  assign bypass_sel = ~idcode_sel & ~|dr_sel;

  always_comb begin
    tdo_d = bypass_q;
    if (state_q == ShiftIr) tdo_d = ir_shift_q[0];
    else if (idcode_sel)    tdo_d = idcode_q[0];
    else if (|dr_sel)       tdo_d = |(dmi.user_tdo_i & dr_sel);
  end

  always_ff @(posedge clk_i) begin
    if (tap_rst) begin
      ir_q       <= IrLength'(IR_IDCODE);
      ir_shift_q <= '0;
      idcode_q   <= IdcodeValue;
      bypass_q   <= 1'b0;
      td_o       <= 1'b0;
      tdo_oe_o   <= 1'b0;
    end else begin
      if (tck_rise) begin
        case (state_q)
          TestLogicReset: ir_q       <= IrLength'(IR_IDCODE);
          CaptureIr:      ir_shift_q <= IrLength'(2'b01);
          ShiftIr:        ir_shift_q <= {tdi_s, ir_shift_q[IrLength-1:1]};
          UpdateIr:       ir_q       <= ir_shift_q;
          CaptureDr: begin
            if (idcode_sel) idcode_q <= IdcodeValue;
            if (bypass_sel) bypass_q <= 1'b0;
          end
          ShiftDr: begin
            if (idcode_sel) idcode_q <= {tdi_s, idcode_q[IdcodeWidth-1:1]};
            if (bypass_sel) bypass_q <= tdi_s;
          end
          default: ;
        endcase
      end
      // TDO only moves on the falling edge so the host samples it stable on the next rise
      if (tck_fall) begin
        td_o     <= tdo_d;
        tdo_oe_o <= (state_q == ShiftIr) || (state_q == ShiftDr);
      end
    end
  end

  assign dmi.tck_rise_o  = tck_rise & ~tap_rst;
  assign dmi.tdi_o       = tdi_s;
  assign dmi.capture_o   = (state_q == CaptureDr);
  assign dmi.shift_o     = (state_q == ShiftDr);
  assign dmi.update_o    = (state_q == UpdateDr);
  assign dmi.dr_select_o = dr_sel;
  assign dmi.dmi_clear_o = (state_q == TestLogicReset);

endmodule
